pwm_capture: RTL and testbench

- Receive end of the PWM link. Samples a PWM waveform whose period starts low (low for N cycles, then high to the end of the period) and recovers the low count N and the period length.
- Clamps N to CNT_NUM. Flags lines stuck at 0% or 100% duty.
- Sits on the sink side of a PWM wire, feeding the recovered duty value to control or readback logic.

---
 rtl/pwm_capture_pkg.sv | 17 +
 rtl/pwm_sync_edge.sv | 35 +++
 rtl/pwm_capture.sv | 144 ++++++++++++++
 tb/tb_pwm_capture.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture receiver.
//   state_e   : capture FSM states (idle / low phase / high phase / stuck line)
//   get_width : number of bits needed to hold the value v (minimum 1)
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_STUCK
  } state_e;

  function automatic int unsigned get_width(input int unsigned v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Three-flop synchronizer with edge detect for an asynchronous line.
//   clk    : sampling clock
//   rst    : asynchronous active-low reset, flops reset to 1 (idle-high line)
//   line_i : raw asynchronous line
//   level_o: synchronized level (second flop)
//   rise_o : one-cycle pulse on a synchronized rising edge
//   fall_o : one-cycle pulse on a synchronized falling edge
module pwm_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= line_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = ~s3_q & s2_q;
  assign fall_o  = s3_q & ~s2_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture receiver. Measures the low-phase length and the period
// (falling edge to falling edge) of a low-first PWM line, and flags a line
// with no edge for TIMEOUT clocks as stuck.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   pwm_in   : PWM line, may be asynchronous to clk
//   duty_low : last low-phase length, clamped to CNT_NUM
//   period   : last period length, 0 while stuck
//   valid    : one-cycle pulse whenever duty_low/period/stuck update
//   stuck    : line has had no edge for TIMEOUT clocks
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_NUM   = 8,
  parameter int unsigned CNT_WIDTH = get_width(CNT_NUM),
  parameter int unsigned TIMEOUT   = 2 * CNT_NUM,
  parameter int unsigned P_WIDTH   = get_width(TIMEOUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] duty_low,
  output logic [P_WIDTH-1:0]   period,
  output logic                 valid,
  output logic                 stuck
);

  localparam logic [P_WIDTH-1:0]   TMO     = P_WIDTH'(TIMEOUT);
  localparam logic [P_WIDTH-1:0]   CLAMP_P = P_WIDTH'(CNT_NUM);
  localparam logic [CNT_WIDTH-1:0] CLAMP_C = CNT_WIDTH'(CNT_NUM);

  state_e               state_q, state_d;
  logic [P_WIDTH-1:0]   cnt_q, cnt_d;
  logic [P_WIDTH-1:0]   low_len_q, low_len_d;
  logic [CNT_WIDTH-1:0] duty_q, duty_d;
  logic [P_WIDTH-1:0]   period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 stuck_q, stuck_d;

  logic level, rise, fall;
  logic timeout;
  logic enter_stuck, stuck_lvl;

  pwm_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (pwm_in),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign timeout = (cnt_q == TMO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      low_len_q <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      low_len_q <= low_len_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      stuck_q   <= stuck_d;
    end
  end

  // Edges take priority over the timeout in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fall) state_d = ST_LOW;  else if (timeout) state_d = ST_STUCK;
      ST_LOW:   if (rise) state_d = ST_HIGH; else if (timeout) state_d = ST_STUCK;
      ST_HIGH:  if (fall) state_d = ST_LOW;  else if (timeout) state_d = ST_STUCK;
      ST_STUCK: if (fall) state_d = ST_LOW;  else if (rise)    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = timeout ? cnt_q : cnt_q + P_WIDTH'(1);
    low_len_d   = low_len_q;
    duty_d      = duty_q;
    period_d    = period_q;
    stuck_d     = stuck_q;
    valid_d     = 1'b0;
    enter_stuck = 1'b0;
    stuck_lvl   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          cnt_d = P_WIDTH'(1);
        end else if (timeout) begin
          enter_stuck = 1'b1;
          stuck_lvl   = level;
        end
      end
      ST_LOW: begin
        if (rise) begin
          low_len_d = cnt_q;
        end else if (timeout) begin
          enter_stuck = 1'b1;
          stuck_lvl   = 1'b0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          cnt_d    = P_WIDTH'(1);
          period_d = cnt_q;
          duty_d   = (low_len_q > CLAMP_P) ? CLAMP_C : low_len_q[CNT_WIDTH-1:0];
          stuck_d  = 1'b0;
          valid_d  = 1'b1;
        end else if (timeout) begin
          enter_stuck = 1'b1;
          stuck_lvl   = 1'b1;
        end
      end
      ST_STUCK: begin
        if (fall) cnt_d = P_WIDTH'(1);
        else if (rise) cnt_d = '0;
      end
      default: ;
    endcase
    if (enter_stuck) begin
      stuck_d  = 1'b1;
      period_d = '0;
      duty_d   = stuck_lvl ? '0 : CLAMP_C;
      valid_d  = 1'b1;
    end
  end

  assign duty_low = duty_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign stuck    = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (CNT_NUM=8, TIMEOUT=16). Expected reports are queued
// as each stimulus pattern is started and checked whenever valid pulses.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [3:0] duty_low;
  logic [4:0] period;
  logic       valid;
  logic       stuck;

  always #5 clk = ~clk;

  pwm_capture #(
    .CNT_NUM(8),
    .TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pwm_in  (pwm_in),
    .duty_low(duty_low),
    .period  (period),
    .valid   (valid),
    .stuck   (stuck)
  );

  typedef struct {
    int unsigned duty;
    int unsigned per;
    int unsigned stk;
    int unsigned gap;  // expected clocks since previous valid, 0 = unchecked
  } rep_t;

  rep_t        sb[$];
  rep_t        mon_e;
  int unsigned n_cmp    = 0;
  int unsigned n_err    = 0;
  int unsigned cyc      = 0;
  int unsigned last_cyc = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_rep(input int unsigned d, input int unsigned p,
                            input int unsigned s, input int unsigned g);
    rep_t e;
    e.duty = d;
    e.per  = p;
    e.stk  = s;
    e.gap  = g;
    sb.push_back(e);
  endtask

  // k consecutive clean reports of an n_low/8 waveform
  task automatic expect_stream(input int unsigned n_low, input int unsigned k, input int unsigned first_gap);
    for (int unsigned i = 0; i < k; i++)
      expect_rep(n_low, 8, 0, (i == 0) ? first_gap : 8);
  endtask

  task automatic hold(input logic v, input int unsigned n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_periods(input int unsigned n_low, input int unsigned k);
    for (int unsigned i = 0; i < k; i++) begin
      hold(1'b0, n_low);
      hold(1'b1, 8 - n_low);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_duty"},   duty_low, 0);
    check_eq({tag, "_period"}, period,   0);
    check_eq({tag, "_stuck"},  stuck,    0);
    check_eq({tag, "_valid"},  valid,    0);
  endtask

  task automatic do_reset();
    pwm_in = 1'b1;
    rst    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    hold(1'b1, 2);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      check_eq("valid_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_eq("duty_low", duty_low, mon_e.duty);
        check_eq("period",   period,   mon_e.per);
        check_eq("stuck",    stuck,    mon_e.stk);
        if (mon_e.gap != 0) check_eq("valid_gap", cyc - last_cyc, mon_e.gap);
      end
      last_cyc = cyc;
    end
  end

  initial begin
    pwm_in = 1'b1;
    rst    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b1;
    hold(1'b1, 2);

    // steady 3/8 from reset
    expect_stream(3, 6, 0);
    drive_periods(3, 6);
    hold(1'b0, 6);
    check_eq("sb_left_steady3", sb.size(), 0);
    do_reset();

    // line always high: single stuck-high report
    expect_rep(0, 0, 1, 0);
    hold(1'b1, 40);
    check_eq("sb_left_high", sb.size(), 0);
    do_reset();

    // line always low, then 5/8
    expect_rep(8, 0, 1, 0);
    expect_stream(5, 3, 0);
    hold(1'b0, 30);
    drive_periods(5, 4);
    hold(1'b0, 6);
    check_eq("sb_left_low_to5", sb.size(), 0);
    do_reset();

    // duty change 3 -> 6 at a period boundary
    expect_stream(3, 3, 0);
    expect_stream(6, 3, 8);
    drive_periods(3, 3);
    drive_periods(6, 3);
    hold(1'b0, 6);
    check_eq("sb_left_3to6", sb.size(), 0);
    do_reset();

    // long low (20) / high (4), then 1-low glitch periods
    expect_rep(8, 0, 1, 0);
    expect_stream(1, 4, 0);
    hold(1'b0, 20);
    hold(1'b1, 4);
    drive_periods(1, 4);
    hold(1'b0, 6);
    check_eq("sb_left_glitch", sb.size(), 0);
    do_reset();

    // asynchronous reset during a high phase
    expect_stream(3, 3, 0);
    drive_periods(3, 3);
    hold(1'b0, 3);
    hold(1'b1, 4);
    check_eq("pre_rst_duty", duty_low, 3);
    #3;
    rst = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    check_eq("sb_left_pre_rst", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    hold(1'b1, 2);
    expect_stream(3, 4, 0);
    drive_periods(3, 4);
    hold(1'b0, 6);
    check_eq("sb_left_post_rst", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
